// File: rtl/logic_sweep_pkg.sv
// Shared encodings for the logic sweep checker: reference-function op codes and FSM states.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_ref_gate.sv
// Golden model: reduction of a vector under the selected op.
// Purely combinational, zero latency, no flow control.
module logic_ref_gate
    import logic_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  op_t             op,
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    always_comb begin
        expected = 1'b0;
        unique case (op)
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_XOR:  expected = ^vec;
            OP_NAND: expected = ~&vec;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_sweep_checker.sv
// Exhaustively sweeps all 2^N_IN vectors into a DUT and counts mismatches against a reference op.
// Each vector is held LAT+1 cycles and compared in the last one; no backpressure, start is a level request.
module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam logic [2:0]      LAT_CNT  = 3'(LAT);
    localparam logic [N_IN-1:0] ALL_ONES = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    state_t     state, state_nxt;
    op_t        op_q;
    logic [2:0] wait_cnt;
    logic       expected;
    logic       cmp_now;
    logic       mismatch;

    logic_ref_gate #(.N_IN(N_IN)) u_ref (
        .op       (op_q),
        .vec      (dut_in),
        .expected (expected)
    );

    assign cmp_now  = (state == ST_APPLY) && (wait_cnt == LAT_CNT);
    assign mismatch = cmp_now && (dut_out != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                busy = 1'b1;
                if (cmp_now && (dut_in == ALL_ONES)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (err_cnt == '0);
                if (!start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Results are only touched by an accepted start or a compare, so they survive DONE->IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q             <= OP_AND;
            dut_in           <= '0;
            wait_cnt         <= '0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q             <= op_t'(op);
                        dut_in           <= '0;
                        wait_cnt         <= '0;
                        err_cnt          <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (cmp_now) begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + ERR_ONE;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= dut_in;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (dut_in != ALL_ONES) begin
                            dut_in   <= dut_in + VEC_ONE;
                            wait_cnt <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/logic_sweep_checker.md
LOGIC_SWEEP_CHECKER -- requirements
Module: logic_sweep_checker

Interface
REQ-001 Parameter N_IN, default 2: number of DUT inputs; legal range 1..8.
REQ-002 Parameter LAT, default 0: DUT latency in clock cycles; legal range 0..7.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: sweep request, sampled in IDLE only.
REQ-006 Port op, input, 2 bits: reference function; 0=AND, 1=OR, 2=XOR, 3=NAND; latched on an accepted start.
REQ-007 Port dut_in, output, N_IN bits: registered stimulus vector driven to the DUT.
REQ-008 Port dut_out, input, 1 bit: DUT result under test.
REQ-009 Port busy, output, 1 bit: high while the sweep runs.
REQ-010 Port done, output, 1 bit: high while in DONE.
REQ-011 Port pass, output, 1 bit: high in DONE when err_cnt is 0.
REQ-012 Port err_cnt, output, N_IN+1 bits: number of mismatching vectors.
REQ-013 Port first_fail_vec, output, N_IN bits: first mismatching vector.
REQ-014 Port first_fail_valid, output, 1 bit: first_fail_vec holds a capture.

Function
REQ-015 The FSM SHALL have three states: IDLE, APPLY and DONE.
REQ-016 IDLE with start=1 SHALL latch op, clear err_cnt, first_fail_valid and first_fail_vec, set dut_in=0, clear the wait counter, and go to APPLY.
REQ-017 APPLY SHALL hold dut_in for exactly LAT+1 cycles; busy=1 throughout APPLY.
REQ-018 In the last cycle of each hold (wait counter = LAT), the block SHALL compare dut_out with the expected value of the latched op applied to dut_in.
REQ-019 Expected values: AND = reduction-AND, OR = reduction-OR, XOR = reduction-XOR, NAND = inverted reduction-AND.
REQ-020 On a mismatch, err_cnt SHALL increment by 1; on the first mismatch of a sweep, dut_in SHALL be captured into first_fail_vec and first_fail_valid set to 1.
REQ-021 After a compare, dut_in SHALL increment by 1 and the wait counter SHALL clear, except at the all-ones vector.
REQ-022 After the all-ones vector compares, the FSM SHALL go to DONE with no wrap of dut_in to 0.
REQ-023 Total APPLY duration SHALL be exactly 2^N_IN*(LAT+1) cycles; done SHALL rise on the cycle after the final compare.
REQ-024 err_cnt SHALL count up to 2^N_IN without overflow; its N_IN+1-bit width makes saturation unnecessary.
REQ-025 start SHALL be ignored in APPLY; the latched op SHALL not change mid-sweep.
REQ-026 DONE SHALL hold done, pass, err_cnt and the first-fail outputs stable, and SHALL return to IDLE when start=0.
REQ-027 In IDLE, done and busy SHALL be 0, and results SHALL stay readable until the next accepted start.

Reset
REQ-028 rst_n=0 SHALL force IDLE at any time, including mid-sweep, with no pending compare completing.
REQ-029 Reset values SHALL be 0 for dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid, the latched op and the wait counter.

Structure
REQ-030 Package logic_sweep_pkg SHALL hold the op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND) and the FSM state type.
REQ-031 Sub-module logic_ref_gate, parametrised by N_IN, SHALL compute the combinational expected value from op and a vector.
REQ-032 The top level SHALL contain only the FSM, the counters and the result registers.

Verification
REQ-033 Scenario: N_IN=2, LAT=0, correct AND DUT, op=0 -> dut_in steps 00,01,10,11 over 4 cycles, then done=1, pass=1, err_cnt=0.
REQ-034 Scenario: AND DUT stuck at 0, op=0 -> err_cnt=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0.
REQ-035 Scenario: correct AND DUT, op=2 (XOR) -> err_cnt=3, first_fail_vec=2'b01.
REQ-036 Scenario: LAT=2 with a two-stage registered AND DUT -> busy for 12 cycles, pass=1.
REQ-037 Scenario: start pulsed mid-sweep with op changed -> no restart, and results reflect the original op.
REQ-038 Scenario: rst_n=0 asserted at vector 10 -> all outputs 0 immediately; a new start performs a full sweep from 00.
